// File: rtl/am_tx_modulator.sv
// am_tx_modulator
//   1-bit AM transmitter. Signed audio samples arrive over a valid/ready
//   handshake into a one-entry buffer and are linearly interpolated up to the
//   clock rate over segments of 2^INTERP_LOG2 clocks. The envelope
//   (1 + audio/2), scaled to [0, 2^(BITS-1)-1], multiplies the NCO carrier.
//   A first-order sigma-delta turns the product into a 1-bit RF stream.
//
// Ports
//   CLK          system clock
//   RSTb         asynchronous active-low reset
//   enable       1 = modulate; 0 = freeze interpolator, clear sigma-delta
//   audio_in     signed audio sample (BITS)
//   audio_valid  audio_in valid
//   audio_ready  input buffer empty; a sample is taken on valid & ready
//   cos_in       signed carrier from the NCO (BITS)
//   RF_out       1-bit modulated RF
//   env_out      registered envelope (BITS, non-negative)
//   underrun     1-cycle pulse when a segment starts with the buffer empty

module am_tx_modulator #(
    parameter int BITS        = 16,
    parameter int INTERP_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic                   enable,
    input  logic signed [BITS-1:0] audio_in,
    input  logic                   audio_valid,
    output logic                   audio_ready,
    input  logic signed [BITS-1:0] cos_in,
    output logic                   RF_out,
    output logic signed [BITS-1:0] env_out,
    output logic                   underrun
);

    localparam int ACC_W = BITS + INTERP_LOG2 + 1;
    localparam int SD_W  = BITS + 2;

    localparam logic signed [BITS-1:0] ENV_OFS = BITS'(2 ** (BITS - 2));
    localparam logic signed [SD_W-1:0] FS_POS  = SD_W'(2 ** (BITS - 1));
    localparam logic signed [SD_W-1:0] FS_NEG  = -FS_POS;

    // input buffer
    logic signed [BITS-1:0]   buf_q;
    logic                     buf_full;

    // interpolator
    logic [INTERP_LOG2-1:0]   phase_q;
    logic signed [BITS-1:0]   cur_q;
    logic signed [BITS-1:0]   nxt_q;
    logic signed [BITS:0]     delta_q;
    logic signed [ACC_W-1:0]  acc_q;

    // pipeline and sigma-delta
    logic signed [BITS-1:0]   cos_q;
    logic signed [BITS-1:0]   prod_q;
    logic signed [SD_W-1:0]   integ_q;

    // combinational helpers
    logic                     seg_load;
    logic signed [BITS-1:0]   cur_new;
    logic signed [BITS-1:0]   nxt_new;
    logic signed [BITS-1:0]   interp;
    logic signed [BITS-1:0]   env;
    logic signed [2*BITS-1:0] prod_full;
    logic signed [SD_W-1:0]   sd_sum;

    assign audio_ready = !buf_full;

    always_comb begin
        seg_load  = enable && (phase_q == '0);
        cur_new   = nxt_q;
        // An empty buffer at segment start repeats the last sample.
        nxt_new   = buf_full ? buf_q : nxt_q;
        interp    = BITS'(acc_q >>> INTERP_LOG2);
        env       = (interp >>> 1) + ENV_OFS;
        prod_full = env_out * cos_q;
        sd_sum    = integ_q + SD_W'(prod_q) - (RF_out ? FS_POS : FS_NEG);
    end

    // One-entry buffer. Acceptance ignores enable. A load only drains a full
    // buffer and an accept only fills an empty one, so they never collide;
    // a sample accepted during a load that found the buffer empty waits for
    // the following segment.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            buf_q    <= '0;
            buf_full <= 1'b0;
        end else begin
            if (seg_load && buf_full)
                buf_full <= 1'b0;
            if (audio_valid && !buf_full) begin
                buf_q    <= audio_in;
                buf_full <= 1'b1;
            end
        end
    end

    // Interpolator: acc carries cur * N plus k * delta, so acc >>> INTERP_LOG2
    // walks from cur towards next in N equal steps.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            phase_q  <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            delta_q  <= '0;
            acc_q    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (enable) begin
                phase_q <= phase_q + INTERP_LOG2'(1);
                if (seg_load) begin
                    cur_q    <= cur_new;
                    nxt_q    <= nxt_new;
                    delta_q  <= (BITS+1)'(nxt_new) - (BITS+1)'(cur_new);
                    acc_q    <= ACC_W'(cur_new) <<< INTERP_LOG2;
                    underrun <= !buf_full;
                end else begin
                    acc_q <= acc_q + ACC_W'(delta_q);
                end
            end
        end
    end

    // Three-stage datapath: envelope/carrier register, product, sigma-delta.
    // Disabling clears the product and loop so a restart begins from rest;
    // the envelope and carrier registers simply hold.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            env_out <= '0;
            cos_q   <= '0;
            prod_q  <= '0;
            integ_q <= '0;
            RF_out  <= 1'b0;
        end else if (enable) begin
            env_out <= env;
            cos_q   <= cos_in;
            // env_out < 2^(BITS-1) keeps |product| >> (BITS-1) below full scale.
            prod_q  <= BITS'(prod_full >>> (BITS - 1));
            integ_q <= sd_sum;
            RF_out  <= !sd_sum[SD_W-1];
        end else begin
            prod_q  <= '0;
            integ_q <= '0;
            RF_out  <= 1'b0;
        end
    end

endmodule
